// File: rtl/expand_key.sv
// One AES-128 key-schedule round: next round key from the current key and round number.
// Define EXPAND_KEY_COMB_OUT_EN to bypass the output register (zero latency, clk/rst_n unused).
module expand_key (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic [7:0]   count,
    input  logic         in_valid,
    output logic [127:0] exkey,
    output logic         out_valid
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic [7:0]   w_rcon;
    logic [127:0] w_next;

    assign {w_w0, w_w1, w_w2, w_w3} = key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // One S-box lookup per byte of the rotated word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[gi*8 +: 8] = SBOX[w_rot[gi*8 +: 8]];
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (count)
            8'd1:    w_rcon = 8'h01;
            8'd2:    w_rcon = 8'h02;
            8'd3:    w_rcon = 8'h04;
            8'd4:    w_rcon = 8'h08;
            8'd5:    w_rcon = 8'h10;
            8'd6:    w_rcon = 8'h20;
            8'd7:    w_rcon = 8'h40;
            8'd8:    w_rcon = 8'h80;
            8'd9:    w_rcon = 8'h1b;
            8'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_t    = w_sub ^ {w_rcon, 24'h0};
    assign w_w4   = w_w0 ^ w_t;
    assign w_w5   = w_w1 ^ w_w4;
    assign w_w6   = w_w2 ^ w_w5;
    assign w_w7   = w_w3 ^ w_w6;
    assign w_next = {w_w4, w_w5, w_w6, w_w7};

`ifdef EXPAND_KEY_COMB_OUT_EN
    logic w_unused;
    assign w_unused  = ^{clk, rst_n};
    assign exkey     = w_next;
    assign out_valid = in_valid;
`else
    logic [127:0] r_exkey;
    logic         r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exkey     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid)
                r_exkey <= w_next;
        end
    end

    assign exkey     = r_exkey;
    assign out_valid = r_out_valid;
`endif

endmodule

// File: tb/tb_expand_key.sv
// Directed testbench for expand_key using FIPS-197 key-expansion vectors.
// Honours EXPAND_KEY_COMB_OUT_EN when the design is built with it.
module tb_expand_key;

    logic         clk;
    logic         rst_n;
    logic [127:0] key;
    logic [7:0]   count;
    logic         in_valid;
    logic [127:0] exkey;
    logic         out_valid;

    int unsigned n_tests;
    int unsigned n_fail;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    expand_key u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .count     (count),
        .in_valid  (in_valid),
        .exkey     (exkey),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector, then sample just after the capturing edge.
    task automatic apply(input logic [127:0] k, input logic [7:0] c);
        @(negedge clk);
        key      = k;
        count    = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
`ifndef EXPAND_KEY_COMB_OUT_EN
        rst_n    = 1'b0;
        key      = K0;
        count    = 8'd1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (exkey !== 128'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: exkey=%h out_valid=%b, required 0/0", exkey, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #2;
        n_tests++;
        if (exkey !== 128'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: exkey=%h out_valid=%b, required 0/0", exkey, out_valid);
        end
        apply(K0, 8'd1);
        n_tests++;
        if (exkey !== K1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first: exkey=%h out_valid=%b, required %h/1", exkey, out_valid, K1);
        end
        // Asynchronous assertion mid-operation clears outputs without a clock edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (exkey !== 128'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: exkey=%h out_valid=%b, required 0/0", exkey, out_valid);
        end
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
`else
        rst_n    = 1'b1;
        in_valid = 1'b0;
        key      = '0;
        count    = '0;
        @(negedge clk);
`endif
    endtask

    task automatic test_fips_vectors();
        apply(K0, 8'd1);
        n_tests++;
        if (exkey !== K1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL round1: exkey=%h out_valid=%b, required %h/1", exkey, out_valid, K1);
        end
        apply(K1, 8'd2);
        n_tests++;
        if (exkey !== K2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL round2: exkey=%h out_valid=%b, required %h/1", exkey, out_valid, K2);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        k = K0;
        for (int r = 1; r <= 10; r++) begin
            apply(k, 8'(r));
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL chain_valid r=%0d: out_valid=%b, required 1", r, out_valid);
            end
            k = exkey;
        end
        n_tests++;
        if (k !== K10) begin
            n_fail++;
            $display("FAIL chain_final: exkey=%h, required %h", k, K10);
        end
    endtask

    task automatic test_rcon_bounds();
        apply('0, 8'd1);
        n_tests++;
        if (exkey !== 128'h62636363626363636263636362636363) begin
            n_fail++;
            $display("FAIL zero_c1: exkey=%h, required 62636363626363636263636362636363", exkey);
        end
        apply('0, 8'd0);
        n_tests++;
        if (exkey !== 128'h63636363636363636363636363636363) begin
            n_fail++;
            $display("FAIL zero_c0: exkey=%h, required 63636363636363636363636363636363", exkey);
        end
        apply('0, 8'd10);
        n_tests++;
        if (exkey !== 128'h55636363556363635563636355636363) begin
            n_fail++;
            $display("FAIL zero_c10: exkey=%h, required 55636363556363635563636355636363", exkey);
        end
        apply('0, 8'd11);
        n_tests++;
        if (exkey !== 128'h63636363636363636363636363636363) begin
            n_fail++;
            $display("FAIL zero_c11: exkey=%h, required 63636363636363636363636363636363", exkey);
        end
        apply('0, 8'd255);
        n_tests++;
        if (exkey !== 128'h63636363636363636363636363636363) begin
            n_fail++;
            $display("FAIL zero_c255: exkey=%h, required 63636363636363636363636363636363", exkey);
        end
    endtask

    task automatic test_hold();
        logic [127:0] exp;
        apply(K0, 8'd1);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef EXPAND_KEY_COMB_OUT_EN
        exp = K1;
`else
        key   = '0;
        count = 8'd1;
        exp   = K1;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b0 || exkey !== exp) begin
                n_fail++;
                $display("FAIL hold%0d: exkey=%h out_valid=%b, required %h/0", i, exkey, out_valid, exp);
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        key      = '0;
        count    = '0;
        in_valid = 1'b0;
        test_reset();
        test_fips_vectors();
        test_back_to_back();
        test_rcon_bounds();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
